// File: rtl/result_collector.sv
// result_collector
//
// Collects finished results from NumEus execution units and turns them into
// register-file writebacks. A round-robin arbiter picks one valid EU per
// cycle. The winner is captured into a single-entry output slot, and that slot
// drives the register-file write port. When the register file accepts the
// write, a one-cycle completion pulse carries the instruction tag to the
// scoreboard so it can release the destination register.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rc_to_eu_ready_o     per-EU ready (at most one bit high per cycle)
//   eu_to_rc_valid_i     per-EU result valid
//   eu_to_rc_tag_i       per-EU instruction tag
//   eu_to_rc_dst_i       per-EU destination register index
//   eu_to_rc_data_i      per-EU warp result data
//   rc_to_rf_valid_o     register-file write request (slot full)
//   rf_to_rc_ready_i     register file accepts the write
//   rc_to_rf_dst_o       write address
//   rc_to_rf_data_o      write data
//   rc_to_rf_tag_o       tag of the write (selects the warp bank)
//   rc_to_sb_valid_o     completion pulse, coincident with the RF handshake
//   rc_to_sb_tag_o       tag of the completed instruction
module result_collector #(
  parameter int unsigned NumEus      = 2,
  parameter int unsigned RegWidth    = 32,
  parameter int unsigned WarpWidth   = 4,
  parameter type         iid_t       = logic,
  parameter type         reg_idx_t   = logic,
  parameter type         warp_data_t = logic [RegWidth*WarpWidth-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [NumEus-1:0] rc_to_eu_ready_o,
  input  logic [NumEus-1:0] eu_to_rc_valid_i,
  input  iid_t              eu_to_rc_tag_i  [NumEus],
  input  reg_idx_t          eu_to_rc_dst_i  [NumEus],
  input  warp_data_t        eu_to_rc_data_i [NumEus],
  output logic              rc_to_rf_valid_o,
  input  logic              rf_to_rc_ready_i,
  output reg_idx_t          rc_to_rf_dst_o,
  output warp_data_t        rc_to_rf_data_o,
  output iid_t              rc_to_rf_tag_o,
  output logic              rc_to_sb_valid_o,
  output iid_t              rc_to_sb_tag_o
);

  localparam int unsigned PrioW = (NumEus > 1) ? $clog2(NumEus) : 1;
  typedef logic [PrioW-1:0] prio_t;
  localparam prio_t LastIdx = prio_t'(NumEus - 1);

  // Output slot and arbitration pointer
  logic       full_q, full_d;
  prio_t      prio_q, prio_d;
  iid_t       tag_q,  tag_d;
  reg_idx_t   dst_q,  dst_d;
  warp_data_t data_q, data_d;

  logic  accept;
  logic  drain;
  logic  handshake;
  logic  grant_valid;
  prio_t grant_idx;
  prio_t cand;

  // The slot can take a new result when it is empty or is being drained
  // this cycle, which gives back-to-back throughput with a single entry.
  assign drain     = full_q && rf_to_rc_ready_i;
  assign accept    = !full_q || rf_to_rc_ready_i;
  assign handshake = accept && grant_valid;

  // Round-robin search: first valid EU at or after prio_q, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumEus; k++) begin
      cand = prio_t'((32'(prio_q) + k) % NumEus);
      if (!grant_valid && eu_to_rc_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rc_to_eu_ready_o = '0;
    if (handshake) begin
      rc_to_eu_ready_o[grant_idx] = 1'b1;
    end
  end

  // Drain is applied before load so a same-cycle refill keeps the slot full.
  always_comb begin
    full_d = full_q;
    prio_d = prio_q;
    tag_d  = tag_q;
    dst_d  = dst_q;
    data_d = data_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (handshake) begin
      full_d = 1'b1;
      tag_d  = eu_to_rc_tag_i[grant_idx];
      dst_d  = eu_to_rc_dst_i[grant_idx];
      data_d = eu_to_rc_data_i[grant_idx];
      prio_d = (grant_idx == LastIdx) ? '0 : grant_idx + prio_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      prio_q <= '0;
      tag_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      prio_q <= prio_d;
      tag_q  <= tag_d;
      dst_q  <= dst_d;
      data_q <= data_d;
    end
  end

  assign rc_to_rf_valid_o = full_q;
  assign rc_to_rf_dst_o   = dst_q;
  assign rc_to_rf_data_o  = data_q;
  assign rc_to_rf_tag_o   = tag_q;
  assign rc_to_sb_valid_o = drain;
  assign rc_to_sb_tag_o   = tag_q;

  // Protocol properties of the collector itself
  a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rc_to_eu_ready_o));

  a_stall_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (full_q && !rf_to_rc_ready_i) |=> (full_q && $stable(tag_q) && $stable(dst_q)));

  a_sb_needs_rf : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rc_to_sb_valid_o |-> (rc_to_rf_valid_o && rf_to_rc_ready_i));

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

  typedef struct packed {
    logic [3:0]   tag;
    logic [4:0]   dst;
    logic [127:0] data;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rfr   = 1'b0;
  logic sel   = 1'b0;  // 0: observe 2-EU instance, 1: observe 3-EU instance

  always #5 clk = ~clk;

  // Stimulus arrays (3-EU view); the 2-EU instance sees EU0/EU1 of it
  logic [2:0]   v3;
  logic [3:0]   tag3  [3];
  logic [4:0]   dst3  [3];
  logic [127:0] data3 [3];
  logic [1:0]   v2;
  logic [3:0]   tag2  [2];
  logic [4:0]   dst2  [2];
  logic [127:0] data2 [2];

  always_comb begin
    v2 = v3[1:0];
    for (int i = 0; i < 2; i++) begin
      tag2[i]  = tag3[i];
      dst2[i]  = dst3[i];
      data2[i] = data3[i];
    end
  end

  logic [1:0]   rdy2;
  logic         rfv2, sbv2;
  logic [4:0]   rfd2;
  logic [127:0] rfdat2;
  logic [3:0]   rft2, sbt2;
  logic [2:0]   rdy3;
  logic         rfv3, sbv3;
  logic [4:0]   rfd3;
  logic [127:0] rfdat3;
  logic [3:0]   rft3, sbt3;

  result_collector #(
    .NumEus(2), .RegWidth(32), .WarpWidth(4),
    .iid_t(logic [3:0]), .reg_idx_t(logic [4:0])
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .rc_to_eu_ready_o(rdy2), .eu_to_rc_valid_i(v2),
    .eu_to_rc_tag_i(tag2), .eu_to_rc_dst_i(dst2), .eu_to_rc_data_i(data2),
    .rc_to_rf_valid_o(rfv2), .rf_to_rc_ready_i(rfr),
    .rc_to_rf_dst_o(rfd2), .rc_to_rf_data_o(rfdat2), .rc_to_rf_tag_o(rft2),
    .rc_to_sb_valid_o(sbv2), .rc_to_sb_tag_o(sbt2)
  );

  result_collector #(
    .NumEus(3), .RegWidth(32), .WarpWidth(4),
    .iid_t(logic [3:0]), .reg_idx_t(logic [4:0])
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .rc_to_eu_ready_o(rdy3), .eu_to_rc_valid_i(v3),
    .eu_to_rc_tag_i(tag3), .eu_to_rc_dst_i(dst3), .eu_to_rc_data_i(data3),
    .rc_to_rf_valid_o(rfv3), .rf_to_rc_ready_i(rfr),
    .rc_to_rf_dst_o(rfd3), .rc_to_rf_data_o(rfdat3), .rc_to_rf_tag_o(rft3),
    .rc_to_sb_valid_o(sbv3), .rc_to_sb_tag_o(sbt3)
  );

  logic [2:0]   rdy_obs;
  logic         rfv_obs, sbv_obs;
  logic [4:0]   rfd_obs;
  logic [127:0] rfdat_obs;
  logic [3:0]   rft_obs, sbt_obs;

  assign rdy_obs   = sel ? rdy3   : {1'b0, rdy2};
  assign rfv_obs   = sel ? rfv3   : rfv2;
  assign sbv_obs   = sel ? sbv3   : sbv2;
  assign rfd_obs   = sel ? rfd3   : rfd2;
  assign rfdat_obs = sel ? rfdat3 : rfdat2;
  assign rft_obs   = sel ? rft3   : rft2;
  assign sbt_obs   = sel ? sbt3   : sbt2;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Per-EU pending results and the scoreboard of expected RF writes
  item_t q0[$], q1[$], q2[$];
  item_t sb_q[$];
  int    m_prio = 0;
  logic  m_full = 1'b0;

  function automatic item_t mk(input logic [3:0] t, input logic [4:0] d);
    item_t it;
    it.tag  = t;
    it.dst  = d;
    it.data = {$urandom, $urandom, $urandom, $urandom};
    return it;
  endfunction

  function automatic item_t front(input int i);
    case (i)
      0: if (q0.size() != 0) return q0[0];
      1: if (q1.size() != 0) return q1[0];
      default: if (q2.size() != 0) return q2[0];
    endcase
    return '0;
  endfunction

  task automatic push_eu(input int i, input item_t it);
    case (i)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  task automatic pop_eu(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic drive_eus();
    item_t it;
    v3[0] = (q0.size() != 0);
    v3[1] = (q1.size() != 0);
    v3[2] = (q2.size() != 0);
    for (int i = 0; i < 3; i++) begin
      it       = front(i);
      tag3[i]  = it.tag;
      dst3[i]  = it.dst;
      data3[i] = it.data;
    end
  endtask

  // One clock of reference model + checks. Entered just after a rising edge.
  task automatic cycle();
    int         n;
    int         g;
    int         idx;
    logic       acc;
    logic [2:0] er;
    item_t      e;
    item_t      w;
    n = sel ? 3 : 2;
    @(negedge clk);
    acc = !m_full || rfr;
    g   = -1;
    for (int k = 0; k < n; k++) begin
      idx = (m_prio + k) % n;
      if (g < 0 && v3[idx]) g = idx;
    end
    er = '0;
    if (acc && g >= 0) er[g] = 1'b1;
    check_eq("eu_ready", 128'(rdy_obs), 128'(er));
    check_eq("rf_valid", 128'(rfv_obs), 128'(m_full));
    if (m_full) begin
      e = sb_q[0];
      check_eq("rf_tag",  128'(rft_obs), 128'(e.tag));
      check_eq("rf_dst",  128'(rfd_obs), 128'(e.dst));
      check_eq("rf_data", rfdat_obs, e.data);
      check_eq("sb_valid", 128'(sbv_obs), 128'(rfr));
      if (rfr) begin
        check_eq("sb_tag", 128'(sbt_obs), 128'(e.tag));
        void'(sb_q.pop_front());
        m_full = 1'b0;
      end
    end else begin
      check_eq("sb_valid_idle", 128'(sbv_obs), 128'(0));
    end
    if (acc && g >= 0) begin
      w = front(g);
      sb_q.push_back(w);
      pop_eu(g);
      m_prio = (g + 1) % n;
      m_full = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("prio", sel ? 128'(dut3.prio_q) : 128'(dut2.prio_q), 128'(m_prio));
    drive_eus();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int c;
    c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0 || m_full) && c < max_cycles) begin
      cycle();
      c++;
    end
    check_eq("drained_in_budget", 128'(c < max_cycles), 128'(1));
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    sb_q.delete();
    m_prio = 0;
    m_full = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive_eus();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rf_valid", 128'(rfv_obs), 128'(0));
    check_eq("rst_sb_valid", 128'(sbv_obs), 128'(0));
    check_eq("rst_ready",    128'(rdy_obs), 128'(0));
    check_eq("rst_rf_tag",   128'(rft_obs), 128'(0));
    check_eq("rst_rf_dst",   128'(rfd_obs), 128'(0));
    check_eq("rst_rf_data",  rfdat_obs,     128'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    item_t it;
    v3 = '0;
    for (int i = 0; i < 3; i++) begin
      tag3[i]  = '0;
      dst3[i]  = '0;
      data3[i] = '0;
    end
    #1;
    sel = 1'b0;
    do_reset();

    // Single EU, RF always ready
    rfr    = 1'b1;
    it.tag = 4'd3;
    it.dst = 5'd5;
    it.data = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    push_eu(0, it);
    drive_eus();
    run_until_idle(10);
    cycle();

    // Both EUs continuously valid: grants alternate, one write per cycle
    for (int i = 0; i < 4; i++) begin
      push_eu(0, mk(4'(2 * i), 5'(i)));
      push_eu(1, mk(4'(2 * i + 1), 5'(i + 16)));
    end
    drive_eus();
    run_until_idle(20);

    // RF backpressure with EU1 waiting behind a stalled slot
    rfr = 1'b0;
    push_eu(0, mk(4'd7, 5'd9));
    drive_eus();
    cycle();
    push_eu(1, mk(4'd9, 5'd12));
    drive_eus();
    repeat (3) cycle();
    rfr = 1'b1;
    run_until_idle(10);

    // Pointer wrap on the 3-EU instance
    sel = 1'b1;
    do_reset();
    push_eu(0, mk(4'd1, 5'd1));
    push_eu(1, mk(4'd2, 5'd2));
    drive_eus();
    run_until_idle(10);
    check_eq("prio_before_wrap", 128'(dut3.prio_q), 128'(2));
    push_eu(2, mk(4'd3, 5'd3));
    push_eu(0, mk(4'd4, 5'd4));
    drive_eus();
    cycle();
    check_eq("prio_wrapped", 128'(dut3.prio_q), 128'(0));
    cycle();
    check_eq("prio_after_eu0", 128'(dut3.prio_q), 128'(1));
    run_until_idle(10);

    // Random traffic with random RF backpressure
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) push_eu(i, mk(4'($urandom), 5'($urandom)));
      end
      rfr = 1'($urandom_range(0, 3) != 0);
      drive_eus();
      cycle();
    end
    rfr = 1'b1;
    run_until_idle(200);

    // Reset while the slot is full and stalled
    rfr = 1'b0;
    push_eu(1, mk(4'd11, 5'd6));
    drive_eus();
    repeat (2) cycle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_rf_valid", 128'(rfv_obs), 128'(0));
    check_eq("async_rst_sb_valid", 128'(sbv_obs), 128'(0));
    model_reset();
    drive_eus();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rfr   = 1'b1;
    push_eu(0, mk(4'd12, 5'd7));
    push_eu(1, mk(4'd13, 5'd8));
    drive_eus();
    cycle();
    check_eq("tie_after_reset_prio", 128'(dut3.prio_q), 128'(1));
    run_until_idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
